graph_row_fetcher: RTL and testbench
====================================

# graph_row_fetcher

Avalon-MM pipelined read master that streams a contiguous block of 32-bit words from SDRAM into the pathfinding compute core. It attaches to the Nios system interconnect, which arbitrates it alongside the CPU onto the SDRAM controller, and presents the fetched words as a valid/ready stream with a last marker. Software, or the compute core, programs a base address and word count, pulses start, and waits for done.

## Interface
- ADDR_W, 32, byte address width on the Avalon master.
- LEN_W, 16, width of the word-count field; maximum transfer is 2^LEN_W-1 words.
- FIFO_DEPTH, 16, output buffer depth in words; power of two, ≥ 4.

Ports:
- clk_clk  in  1  system clock, shared with the Nios system.
- reset_reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of first word; bits [1:0] ignored (treated as 0).
- len  in  LEN_W  number of 32-bit words to fetch.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been accepted downstream.
- avm_address  out  ADDR_W  read address, word aligned.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  interconnect stall.
- avm_readdata  in  32  returned data.
- avm_readdatavalid  in  1  returned data qualifier.
- out_valid  out  1  stream word valid.
- out_data  out  32  stream word.
- out_last  out  1  marks the final word of a transfer.
- out_ready  in  1  downstream accept.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with len≠0 latches base_addr (low two bits cleared) and len, then goes to ISSUE.
  - start with len=0 stays in IDLE, issues no reads and pulses done on the next cycle.
- ISSUE:
  - Hold avm_read high while credit is available and hold it, with the address stable, while waitrequest is high.
  - A request is accepted when avm_read=1 and waitrequest=0. On acceptance, the address advances by 4 and the issue counter decrements.
  - Credit rule: issue only when outstanding + fifo_count < FIFO_DEPTH. This guarantees the FIFO never overflows, because readdatavalid cannot be back-pressured.
  - When the final request is accepted, go to DRAIN.
- DRAIN:
  - Wait until the outstanding count is 0, the FIFO is empty and the last word has been accepted. Then pulse done and return to IDLE.
- Outstanding counter: incremented on request acceptance, decremented on readdatavalid. Simultaneous increment and decrement leave it unchanged.
- A readdatavalid that arrives while outstanding=0 is discarded. This covers stale responses after a reset mid-transfer.
- out_last is asserted with the word whose receive index equals len-1.
- start while busy is ignored. Inputs are not re-sampled until IDLE.
- Reset mid-transfer: on the next edge the state returns to IDLE, the FIFO is flushed, counters clear and avm_read drops. Responses still in flight are dropped by the outstanding=0 rule.
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, out_valid=0, out_data=0, out_last=0.

## Timing
- start accepted at cycle 0: busy=1 and avm_read=1 at cycle 1.
- With no waitrequest and full credit, one request is accepted per cycle.
- readdatavalid at cycle N: the word is written into the FIFO at the edge ending cycle N, and out_valid=1 with that word at cycle N+1.
- FIFO supports simultaneous push and pop when full-1 or empty+1.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- done is asserted in the cycle after the out_last handshake. busy falls in the same cycle as done.
- Back-to-back transfers: a start in the cycle done is high is ignored. The earliest accepted start is one cycle later.

## Configuration
- GRAPH_ROW_FETCHER_STATS_EN
  - Defined: adds outputs stat_stall_cycles [31:0] and stat_words [31:0].
    - stat_stall_cycles counts cycles with avm_read=1 and waitrequest=1.
    - stat_words counts words delivered on the stream.
    - Both counters clear on an accepted start and on reset, and saturate at all-ones.
  - Undefined: the ports and the logic are absent, and stream behaviour is identical.

## Structure
- Shared package graph_fetch_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - the word-size constant BYTES_PER_WORD=4;
  - the default FIFO_DEPTH.
- One sub-module: graph_fetch_fifo. It is a synchronous FIFO, DATA_W=33 (data plus last flag), parameter DEPTH, with registered outputs, count output, and synchronous active-low reset.

## Test plan
- Basic transfer:
  - base_addr=0x0000_1000, len=8, zero-wait slave, out_ready=1.
  - Addresses 0x1000 to 0x101C are issued on consecutive cycles, 8 words are delivered in order, out_last is on word 8, and done pulses once.
- Back-pressure:
  - len=40, FIFO_DEPTH=16, out_ready=0 for 50 cycles, then 1.
  - outstanding + fifo_count never exceeds 16, no data is lost, and all 40 words arrive in order.
- waitrequest stall:
  - Slave asserts waitrequest for 3 cycles on every 4th request.
  - avm_address holds stable during each stall. With STATS_EN, stat_stall_cycles equals 3 × number of stalled requests.
- Zero length:
  - start with len=0.
  - No avm_read, done at cycle 1, busy stays 0.
- Reset mid-transfer:
  - reset_reset_n=0 for 1 cycle while 5 reads are outstanding.
  - All outputs return to reset values. The 5 late readdatavalid beats are discarded and out_valid stays 0. A new len=2 transfer then completes correctly.
- Start while busy:
  - A second start with a different base_addr during a len=4 transfer.
  - It is ignored, only the original 4 addresses are read, and done pulses once.

Source files
------------

// File: rtl/graph_fetch_pkg.sv
// graph_fetch_pkg: shared state type and constants for the graph row fetcher
// Holds the fetch FSM encoding, the Avalon word size in bytes and the default
// output buffer depth used by graph_row_fetcher and graph_fetch_fifo.
package graph_fetch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_FIFO_DEPTH = 16;
endpackage

// File: rtl/graph_fetch_fifo.sv
// graph_fetch_fifo: synchronous first-word-fall-through FIFO with occupancy count
// Ports: clk, rst_n (synchronous, active-low, flushes contents);
//        push_i/wdata_i write side; pop_i read acknowledge;
//        rvalid_o/rdata_o head word (rdata_o is zero while empty); count_o occupancy.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module graph_fetch_fifo
    import graph_fetch_pkg::*;
#(
    parameter int DATA_W = 33,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic                     rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;
    assign do_pop   = pop_i && count_q != '0;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push  = push_i && (count_q != (AW + 1)'(DEPTH) || do_pop);
    assign rvalid_o = count_q != '0;
    assign rdata_o  = rvalid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o  = count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/graph_row_fetcher.sv
// graph_row_fetcher: Avalon-MM pipelined read master streaming a word block as valid/ready/last
// Ports: clk_clk, reset_reset_n (synchronous, active-low);
//        start/base_addr/len request, busy/done status;
//        avm_address/avm_read/avm_waitrequest/avm_readdata/avm_readdatavalid Avalon-MM master;
//        out_valid/out_data/out_last/out_ready output stream.
// Build option GRAPH_ROW_FETCHER_STATS_EN adds stat_stall_cycles and stat_words.
module graph_row_fetcher
    import graph_fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_last,
    input  logic              out_ready
`ifdef GRAPH_ROW_FETCHER_STATS_EN
    ,
    output logic [31:0]       stat_stall_cycles,
    output logic [31:0]       stat_words
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, issue_q, issue_d, rx_q, rx_d;
    logic [CW-1:0]     outst_q, outst_d, fifo_count;
    logic              done_q, done_d;
    logic              fifo_valid;
    logic [32:0]       fifo_rdata;
    logic              credit, start_acc, req_acc, rsp_acc, pop, fin;
    logic              unused_low_addr;
    assign unused_low_addr = ^base_addr[1:0];
    // Words in flight plus words buffered must stay below the depth, since
    // readdatavalid cannot be stalled and must always find a free slot.
    assign credit    = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign avm_read  = state_q == ISSUE && credit;
    assign req_acc   = avm_read && !avm_waitrequest;
    // Beats with nothing outstanding are stale responses from before a reset.
    assign rsp_acc   = avm_readdatavalid && outst_q != '0;
    assign pop       = fifo_valid && out_ready;
    assign fin       = pop && fifo_rdata[32];
    // The cycle done is high still counts as busy for a new request.
    assign start_acc = state_q == IDLE && start && !done_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign avm_address = addr_q;
    assign out_valid   = fifo_valid;
    assign out_data    = fifo_rdata[31:0];
    assign out_last    = fifo_rdata[32];
    always_comb begin
        state_d = state_q;
        addr_d  = req_acc ? addr_q + ADDR_W'(BYTES_PER_WORD) : addr_q;
        len_d   = len_q;
        issue_d = req_acc ? issue_q - LEN_W'(1) : issue_q;
        rx_d    = rsp_acc ? rx_q + LEN_W'(1) : rx_q;
        outst_d = outst_q + CW'(req_acc) - CW'(rsp_acc);
        done_d  = (start_acc && len == '0) || (state_q == DRAIN && fin);
        if (start_acc && len != '0) begin
            state_d = ISSUE;
            addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
            len_d   = len;
            issue_d = len;
            rx_d    = '0;
        end
        if (state_q == ISSUE && req_acc && issue_q == LEN_W'(1)) state_d = DRAIN;
        // Handing over the last word implies every response arrived and the FIFO drained.
        if (state_q == DRAIN && fin) state_d = IDLE;
    end
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            issue_q <= '0;
            rx_q    <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            rx_q    <= rx_d;
            outst_q <= outst_d;
            done_q  <= done_d;
        end
    end
    // Bit 32 carries the last marker alongside each data word.
    graph_fetch_fifo #(
        .DATA_W (33),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push_i   (rsp_acc),
        .wdata_i  ({rx_q == len_q - LEN_W'(1), avm_readdata}),
        .pop_i    (out_ready),
        .rvalid_o (fifo_valid),
        .rdata_o  (fifo_rdata),
        .count_o  (fifo_count)
    );
`ifdef GRAPH_ROW_FETCHER_STATS_EN
    logic [31:0] stall_q, words_q;
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || start_acc) begin
            stall_q <= '0;
            words_q <= '0;
        end else begin
            stall_q <= (avm_read && avm_waitrequest && stall_q != '1) ? stall_q + 32'd1 : stall_q;
            words_q <= (pop && words_q != '1) ? words_q + 32'd1 : words_q;
        end
    end
    assign stat_stall_cycles = stall_q;
    assign stat_words        = words_q;
`endif
endmodule

// File: tb/tb_graph_row_fetcher.sv
// tb_graph_row_fetcher: directed self-checking bench for graph_row_fetcher
// Drives a pipelined Avalon slave model whose read data is the bitwise inverse of the address.
module tb_graph_row_fetcher;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        wreq = 1'b0, rdv = 1'b0;
    logic [31:0] rdata = '0;
    logic        busy, done, avm_read, out_valid, out_last;
    logic [31:0] avm_address, out_data;
`ifdef GRAPH_ROW_FETCHER_STATS_EN
    logic [31:0] stat_stall, stat_words;
`endif
    int n_chk = 0, n_fail = 0;
    int cyc = 0, lat = 2;
    bit stall_mode = 0, credit_chk = 1, prev_wr = 0;
    logic [31:0] exp_base = '0, prev_addr = '0;
    int exp_len = 0, req_i = 0, rx_i = 0, done_n = 0, acc_n = 0, pop_n = 0, st_cnt = 0;
    int acc_first = 0, acc_last = 0;
    logic [31:0] q_data[$];
    int q_due[$];

    graph_row_fetcher dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .len               (len),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (wreq),
        .avm_readdata      (rdata),
        .avm_readdatavalid (rdv),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_ready         (out_ready)
`ifdef GRAPH_ROW_FETCHER_STATS_EN
        ,
        .stat_stall_cycles (stat_stall),
        .stat_words        (stat_words)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Slave and stream monitor; everything here is sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (prev_wr) begin
            chk("hold_addr", avm_address, prev_addr);
            chk("hold_read", 32'(avm_read), 1);
        end
        wreq = 1'b0;
        if (avm_read) begin
            if (stall_mode && req_i % 4 == 3 && st_cnt < 3) begin
                wreq = 1'b1;
                st_cnt++;
            end else begin
                chk("addr", avm_address, exp_base + 32'(req_i) * 4);
                if (credit_chk) chk("credit", 32'(acc_n - pop_n < 16), 1);
                if (acc_n == 0) acc_first = cyc;
                acc_last = cyc;
                q_data.push_back(~avm_address);
                q_due.push_back(cyc + lat);
                req_i++;
                acc_n++;
                st_cnt = 0;
            end
        end
        prev_wr = wreq;
        prev_addr = avm_address;
        if (out_valid && out_ready) begin
            chk("data", out_data, ~(exp_base + 32'(rx_i) * 4));
            chk("last", 32'(out_last), 32'(rx_i == exp_len - 1));
            rx_i++;
            pop_n++;
        end
        if (done) done_n++;
        rdv = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            rdv = 1'b1;
            rdata = q_data.pop_front();
            q_due.delete(0);
        end
    end

    task automatic run(input logic [31:0] b, input int l, input int hold, input int dup, input bit b2b);
        int t;
        exp_base = {b[31:2], 2'b00};
        exp_len = l;
        req_i = 0; rx_i = 0; done_n = 0; acc_n = 0; pop_n = 0; st_cnt = 0;
        base_addr = b;
        len = 16'(l);
        out_ready = hold == 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_c1", 32'(busy), 32'(l != 0));
        chk("read_c1", 32'(avm_read), 32'(l != 0));
        chk("done_c1", 32'(done), 32'(l == 0));
        t = 0;
        while (!done && t < 3000) begin
            out_ready = t >= hold;
            start = dup > 0 && t == dup;
            if (start) begin
                base_addr = 32'h0000_8000;
                len = 16'd7;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_timeout", 32'(t < 3000), 1);
        chk("busy_at_done", 32'(busy), 0);
        if (b2b) begin
            base_addr = 32'h0000_9000;
            len = 16'd5;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("b2b_ignored", 32'(busy), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_n), 1);
        chk("words", 32'(rx_i), 32'(l));
        chk("reqs", 32'(req_i), 32'(l));
        chk("busy_end", 32'(busy), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_read"}, 32'(avm_read), 0);
        chk({tag, "_addr"}, avm_address, 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, 32'(out_last), 0);
    endtask

    initial begin
        int t, v;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
`ifdef GRAPH_ROW_FETCHER_STATS_EN
        chk("rst_stat_stall", stat_stall, 0);
        chk("rst_stat_words", stat_words, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Basic zero-wait transfer: eight requests on consecutive cycles.
        run(32'h0000_1000, 8, 0, 0, 0);
        chk("consecutive", 32'(acc_last - acc_first), 7);
        // Low address bits are ignored.
        run(32'h0000_4002, 3, 0, 0, 0);
        // Long back-pressure with the credit bound checked on every request.
        run(32'h0002_0000, 40, 50, 0, 0);
        // Every fourth request stalled for three cycles.
        stall_mode = 1;
        run(32'h0000_5000, 12, 0, 0, 0);
        stall_mode = 0;
`ifdef GRAPH_ROW_FETCHER_STATS_EN
        chk("stat_stall", stat_stall, 9);
        chk("stat_words", stat_words, 12);
`endif
        // Zero length: no reads, done in cycle 1, busy never rises.
        run(32'h0000_a000, 0, 0, 0, 0);
        // Second start with another base while busy, then a start during done.
        run(32'h0000_6000, 4, 0, 2, 0);
        run(32'h0000_7000, 3, 0, 0, 1);
        // Reset with reads outstanding; the late beats must be dropped.
        lat = 8;
        credit_chk = 0;
        exp_base = 32'h0000_2000;
        exp_len = 10;
        req_i = 0; rx_i = 0; done_n = 0; acc_n = 0; pop_n = 0;
        base_addr = 32'h0000_2000;
        len = 16'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (acc_n < 5 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("outstanding5", 32'(acc_n), 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset("midrst");
        v = 0;
        repeat (15) begin
            @(posedge clk); #1;
            v += int'(out_valid);
        end
        chk("stale_dropped", 32'(v), 0);
        chk("stale_drained", 32'(q_data.size()), 0);
        lat = 2;
        credit_chk = 1;
        run(32'h0000_3000, 2, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
